// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the multicycle RV32I shared-ALU datapath
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               ALUResultb31,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               RegWrite,
    output logic               InstrDone,
    output logic [STATE_W-1:0] State
);

    localparam logic [STATE_W-1:0] FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] EXECR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] EXECI    = STATE_W'(7);
    localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] BRANCH   = STATE_W'(9);
    localparam logic [STATE_W-1:0] JAL      = STATE_W'(10);
    localparam logic [STATE_W-1:0] LUI      = STATE_W'(11);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    logic [STATE_W-1:0] stateNext;
    logic [1:0]         aluOp;
    logic               branchTaken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) State <= FETCH;
        else       State <= stateNext;
    end

    always_comb begin
        stateNext = FETCH;
        case (State)
            FETCH:  stateNext = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_R:         stateNext = EXECR;
                    OP_I:         stateNext = EXECI;
                    OP_BR:        stateNext = BRANCH;
                    OP_JAL:       stateNext = JAL;
                    OP_LUI:       stateNext = LUI;
                    default:      stateNext = FETCH;
                endcase
            end
            MEMADR:  stateNext = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD: stateNext = MEMWB;
            EXECR, EXECI, JAL, LUI: stateNext = ALUWB;
            default: stateNext = FETCH;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  branchTaken = Zero;
            3'b001:  branchTaken = ~Zero;
            3'b100:  branchTaken = ALUResultb31;
            3'b101:  branchTaken = ~ALUResultb31;
            default: branchTaken = 1'b0;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        InstrDone = 1'b0;
        aluOp     = ALUOP_ADD;
        case (State)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                aluOp   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                aluOp     = ALUOP_SUB;
                PCWrite   = branchTaken;
                InstrDone = 1'b1;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
    end

    // op[5] separates R-type from I-type so addi with instr[30] set stays an add
    always_comb begin
        ALUControl = 3'b000;
        case (aluOp)
            ALUOP_SUB: ALUControl = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b100:  ALUControl = 3'b100;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the shared-ALU, unified-memory multicycle RV32I datapath (non-pipelined core variant).
- Each instruction takes 3–5 cycles. Instruction register, ALUOut and data registers live in the datapath; this block drives their enables and muxes.
- Covers lw, sw, R-type, I-type ALU, beq/bne/blt/bge, jal, lui. Any other opcode is dropped.

Parameters:
- STATE_W, 4, width of the state register and the State debug port.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; forces FETCH
- op  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- Zero  input  1  ALU result == 0
- ALUResultb31  input  1  ALU result sign bit
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction/OldPC register enable
- ResultSrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  ALU A input: 00=PC, 01=OldPC, 10=RD1, 11=zero
- ALUSrcB  output  2  ALU B input: 00=RD2, 01=ImmExt, 10=constant 4
- ImmSrc  output  3  immediate type: I=000, S=001, B=010, J=011, U=100
- ALUControl  output  3  ALU operation: add=000, sub=001, and=010, or=011, xor=100, slt=101
- RegWrite  output  1  register file write enable
- InstrDone  output  1  one-cycle pulse in the final state of each instruction
- State  output  STATE_W  current state, for debug and verification

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11.
- Reset: asynchronous, active-high; State=FETCH immediately, including mid-instruction. Outputs take FETCH values.
- Unlisted controls default to 0. Don't-care selects are driven to 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (computes the branch target).
  - Next state: op 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 0110111 → LUI.
  - Any other opcode → FETCH, with InstrDone=0 and no PC, register or memory write.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
  - Next state: op[5]=0 → MEMREAD; op[5]=1 → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Next state: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, InstrDone=1. Next state: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Next state: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Next state: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, InstrDone=1. Next state: FETCH.
  - PCWrite = taken, evaluated combinationally from funct3:
    - 000: Zero
    - 001: ~Zero
    - 100: ALUResultb31
    - 101: ~ALUResultb31
    - all other funct3 values: not taken
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCWrite=1. Next state: ALUWB (writes PC+4 to rd).
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=add. Next state: ALUWB.
- ALU decode:
  - ALUOp add → 000; sub → 001.
  - ALUOp funct, by funct3:
    - 000: sub if (op[5] & funct7b5), else add
    - 010: slt
    - 100: xor
    - 110: or
    - 111: and
    - other: add
- ImmSrc: decoded from op every cycle, independent of state.
  - lw and I-ALU → 000; sw → 001; branch → 010; jal → 011; lui → 100; otherwise 000.
- Instruction latency in cycles: lw 5; sw, R, I, jal, lui 4; branch 3.
- Outputs are a pure function of State plus op, funct3, funct7b5, Zero and ALUResultb31 (for PCWrite in BRANCH only); no output registers.

Test Plan:
- Reset held, then released with op=0000011 → State sequence 0,1,2,3,4,0. RegWrite=1 only in state 4; IRWrite=1 only in state 0; InstrDone pulses once.
- op=0100011 → sequence 0,1,2,5,0; MemWrite=1 and AdrSrc=1 exactly one cycle (state 5); RegWrite never 1.
- Branches in state 9: funct3=000, Zero=1 → PCWrite=1; Zero=0 → PCWrite=0; funct3=101, ALUResultb31=1 → PCWrite=0; funct3=100, ALUResultb31=1 → PCWrite=1; funct3=010 → PCWrite=0.
- R-type, op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECR. I-type, op=0010011, funct3=000, funct7b5=1 → ALUControl=000 (addi, not sub).
- jal → sequence 0,1,10,8,0 with PCWrite=1 in state 10. lui → 0,1,11,8,0 with ALUSrcA=11 and ImmSrc=100. op=1111111 → 0,1,0, no writes, InstrDone=0.
- Assert reset asynchronously mid-cycle while in MEMREAD → State=0 before the next clock edge; MemWrite and RegWrite stay 0. After release, a full lw completes normally.
